// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester round-robin arbiter for a shared single-port RAM.
// Owner keeps the port for up to MAX_BURST beats while the other side waits.
// Read returns are steered back to the issuer through a READ_LATENCY tag pipe.
module ram_arbiter #(
    parameter int unsigned ADDR_W       = 5,
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned MAX_BURST    = 4
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q
);

    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_0    = 2'd1,
        OWN_1    = 2'd2
    } owner_e;

    owner_e                  owner_q, owner_d;
    logic                    last_q, last_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [READ_LATENCY-1:0] vld_q, vld_d;
    logic [READ_LATENCY-1:0] tid_q, tid_d;

    logic g0, g1;
    logic sel_we;

    // Arbitration: owner retention first, then sole requester, then round-robin tie.
    always_comb begin
        g0 = 1'b0;
        g1 = 1'b0;
        if (!rst) begin
            if (owner_q == OWN_0 && req0 && (count_q < BURST_MAX || !req1)) begin
                g0 = 1'b1;
            end else if (owner_q == OWN_1 && req1 && (count_q < BURST_MAX || !req0)) begin
                g1 = 1'b1;
            end else if (req0 && req1) begin
                if (last_q) g0 = 1'b1;
                else        g1 = 1'b1;
            end else if (req0) begin
                g0 = 1'b1;
            end else if (req1) begin
                g1 = 1'b1;
            end
        end
    end

    // RAM port mux: follows the grantee, parks at zero when idle.
    always_comb begin
        ram_addr = '0;
        ram_data = '0;
        sel_we   = 1'b0;
        if (g0) begin
            ram_addr = addr0;
            ram_data = wdata0;
            sel_we   = we0;
        end else if (g1) begin
            ram_addr = addr1;
            ram_data = wdata1;
            sel_we   = we1;
        end
        ram_wren = sel_we;
    end

    // Next-state: ownership, burst count and read tag pipeline.
    always_comb begin
        owner_d = owner_q;
        last_d  = last_q;
        count_d = count_q;
        vld_d   = '0;
        tid_d   = '0;
        if (g0 || g1) begin
            owner_d = g1 ? OWN_1 : OWN_0;
            last_d  = g1;
            if (owner_d == owner_q) begin
                count_d = (count_q == BURST_MAX) ? count_q : count_q + CNT_ONE;
            end else begin
                count_d = CNT_ONE;
            end
        end else begin
            owner_d = OWN_NONE;
            count_d = '0;
        end
        vld_d[0] = (g0 || g1) && !sel_we;
        tid_d[0] = g1;
        for (int unsigned i = 1; i < READ_LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            tid_d[i] = tid_q[i-1];
        end
    end

    // State registers; reset clears in-flight read tags immediately.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            owner_q <= OWN_NONE;
            last_q  <= 1'b1;
            count_q <= '0;
            vld_q   <= '0;
            tid_q   <= '0;
        end else begin
            owner_q <= owner_d;
            last_q  <= last_d;
            count_q <= count_d;
            vld_q   <= vld_d;
            tid_q   <= tid_d;
        end
    end

    assign gnt0    = g0;
    assign gnt1    = g1;
    assign rvalid0 = vld_q[READ_LATENCY-1] && !tid_q[READ_LATENCY-1];
    assign rvalid1 = vld_q[READ_LATENCY-1] &&  tid_q[READ_LATENCY-1];
    assign rdata   = ram_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter: behavioural RAM plus a transaction-level reference
// model (grant rules, shadow memory, scheduled read returns).
module tb_ram_arbiter;

    localparam int RL = 2;
    localparam int MB = 4;

    logic        clock = 1'b0;
    logic        rst = 1'b0;
    logic        req0, req1, we0, we1;
    logic [4:0]  addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1, ram_wren;
    logic [15:0] rdata, ram_data, ram_q;
    logic [4:0]  ram_addr;

    ram_arbiter #(
        .ADDR_W(5),
        .DATA_W(16),
        .READ_LATENCY(RL),
        .MAX_BURST(MB)
    ) dut (
        .clock(clock), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .ram_addr(ram_addr), .ram_data(ram_data),
        .ram_wren(ram_wren), .ram_q(ram_q)
    );

    always #5 clock = ~clock;

    // Behavioural single-port RAM with RL cycles of read latency.
    logic [15:0] mem [32];
    logic [15:0] qp  [RL];
    always @(posedge clock) begin
        if (ram_wren) mem[ram_addr] <= ram_data;
        qp[0] <= mem[ram_addr];
        for (int i = 1; i < RL; i++) qp[i] <= qp[i-1];
    end
    assign ram_q = qp[RL-1];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int          m_owner, m_last, m_count, cyc, m_g;
    logic [15:0] shadow [32];
    bit          rv_v  [16];
    bit          rv_id [16];
    logic [15:0] rv_d  [16];

    logic [1:0]  exp_gnt, obs_gnt, exp_rv, obs_rv;
    logic        exp_wren, obs_wren;
    logic [4:0]  exp_addr, obs_addr;
    logic [15:0] exp_wd, obs_wd, exp_rd, obs_rd;

    // One clock cycle: predict, sample at negedge, advance model, return after posedge.
    task automatic eval();
        int g;
        int slot;
        @(negedge clock);
        g = -1;
        if (!rst) begin
            if (m_owner == 0 && req0 && (m_count < MB || !req1))      g = 0;
            else if (m_owner == 1 && req1 && (m_count < MB || !req0)) g = 1;
            else if (req0 && req1)                                    g = 1 - m_last;
            else if (req0)                                            g = 0;
            else if (req1)                                            g = 1;
        end
        m_g      = g;
        exp_gnt  = (g == 0) ? 2'b01 : (g == 1) ? 2'b10 : 2'b00;
        exp_wren = (g == 0) ? we0 : (g == 1) ? we1 : 1'b0;
        exp_addr = (g == 0) ? addr0 : (g == 1) ? addr1 : 5'd0;
        exp_wd   = (g == 0) ? wdata0 : (g == 1) ? wdata1 : 16'd0;
        slot     = cyc % 16;
        exp_rv   = (!rst && rv_v[slot]) ? (rv_id[slot] ? 2'b10 : 2'b01) : 2'b00;
        exp_rd   = rv_d[slot];
        rv_v[slot] = 1'b0;
        obs_gnt  = {gnt1, gnt0};
        obs_rv   = {rvalid1, rvalid0};
        obs_rd   = rdata;
        obs_wren = ram_wren;
        obs_addr = ram_addr;
        obs_wd   = ram_data;
        if (rst) begin
            m_owner = -1; m_last = 1; m_count = 0;
            for (int i = 0; i < 16; i++) rv_v[i] = 1'b0;
        end else if (g >= 0) begin
            m_count = (g == m_owner) ? ((m_count + 1 > MB) ? MB : m_count + 1) : 1;
            m_owner = g;
            m_last  = g;
            if (exp_wren) begin
                shadow[exp_addr] = exp_wd;
            end else begin
                slot = (cyc + RL) % 16;
                rv_v[slot]  = 1'b1;
                rv_id[slot] = (g == 1);
                rv_d[slot]  = shadow[exp_addr];
            end
        end else begin
            m_owner = -1;
            m_count = 0;
        end
        cyc++;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; we1 = 1'b1;
        addr0 = 5'd1; addr1 = 5'd2; wdata0 = 16'h0101; wdata1 = 16'h0202;
        for (int k = 0; k < 2; k++) begin
            eval();
            n_tests++;
            if (obs_gnt !== 2'b00) begin n_fail++; $display("FAIL reset_gnt got=%b exp=00", obs_gnt); end
            n_tests++;
            if (obs_wren !== 1'b0 || obs_addr !== 5'd0 || obs_wd !== 16'd0) begin
                n_fail++; $display("FAIL reset_ram got wren=%b addr=%0d data=%h exp 0/0/0", obs_wren, obs_addr, obs_wd);
            end
            n_tests++;
            if (obs_rv !== 2'b00) begin n_fail++; $display("FAIL reset_rvalid got=%b exp=00", obs_rv); end
        end
        rst = 1'b0;
        eval();
        n_tests++;
        if (obs_gnt !== 2'b01) begin n_fail++; $display("FAIL reset_first_gnt got=%b exp=01", obs_gnt); end
        req0 = 1'b0;
        eval();
        n_tests++;
        if (obs_gnt !== 2'b10) begin n_fail++; $display("FAIL reset_second_gnt got=%b exp=10", obs_gnt); end
        req1 = 1'b0;
        eval();
    endtask

    // Sole writer fills every address; exercises saturation of a lone owner.
    task automatic test_fill();
        for (int k = 0; k < 32; k++) begin
            req0 = 1'b1; we0 = 1'b1; addr0 = 5'(k); wdata0 = 16'($urandom);
            eval();
            n_tests++;
            if (obs_gnt !== exp_gnt || obs_gnt !== 2'b01) begin
                n_fail++; $display("FAIL fill_gnt k=%0d got=%b exp=%b", k, obs_gnt, exp_gnt);
            end
            n_tests++;
            if (obs_wren !== 1'b1 || obs_addr !== addr0 || obs_wd !== wdata0) begin
                n_fail++; $display("FAIL fill_ram k=%0d got wren=%b addr=%0d data=%h exp 1/%0d/%h", k, obs_wren, obs_addr, obs_wd, addr0, wdata0);
            end
        end
        req0 = 1'b0;
        eval();
    endtask

    task automatic test_single_burst();
        for (int k = 0; k < 8 + RL + 1; k++) begin
            if (k < 8) begin
                req1 = 1'b1; we1 = 1'b1; addr1 = 5'(3 + k); wdata1 = 16'h1000 + 16'(3 + k);
            end else begin
                req1 = 1'b0;
            end
            eval();
            n_tests++;
            if (obs_gnt !== exp_gnt || obs_gnt !== ((k < 8) ? 2'b10 : 2'b00)) begin
                n_fail++; $display("FAIL burst_gnt k=%0d got=%b exp=%b", k, obs_gnt, exp_gnt);
            end
            n_tests++;
            if (obs_wren !== (k < 8) || obs_addr !== exp_addr || obs_wd !== exp_wd) begin
                n_fail++; $display("FAIL burst_ram k=%0d got wren=%b addr=%0d data=%h exp %b/%0d/%h", k, obs_wren, obs_addr, obs_wd, exp_wren, exp_addr, exp_wd);
            end
            n_tests++;
            if (obs_rv !== exp_rv) begin n_fail++; $display("FAIL burst_rvalid k=%0d got=%b exp=%b", k, obs_rv, exp_rv); end
        end
    endtask

    task automatic test_contention();
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
        addr0 = 5'($urandom); addr1 = 5'($urandom);
        for (int k = 0; k < 24 + RL + 1; k++) begin
            if (k >= 24) begin req0 = 1'b0; req1 = 1'b0; end
            eval();
            n_tests++;
            if (obs_gnt !== exp_gnt) begin n_fail++; $display("FAIL cont_gnt k=%0d got=%b exp=%b", k, obs_gnt, exp_gnt); end
            if (k < 24) begin
                n_tests++;
                if (obs_gnt !== (((k / MB) % 2 == 1) ? 2'b10 : 2'b01)) begin
                    n_fail++; $display("FAIL cont_block k=%0d got=%b exp=%b", k, obs_gnt, (((k / MB) % 2 == 1) ? 2'b10 : 2'b01));
                end
            end
            n_tests++;
            if (obs_rv !== exp_rv) begin n_fail++; $display("FAIL cont_rvalid k=%0d got=%b exp=%b", k, obs_rv, exp_rv); end
            if (exp_rv != 2'b00) begin
                n_tests++;
                if (obs_rd !== exp_rd) begin n_fail++; $display("FAIL cont_rdata k=%0d got=%h exp=%h", k, obs_rd, exp_rd); end
            end
            if (m_g == 0) addr0 = 5'($urandom);
            if (m_g == 1) addr1 = 5'($urandom);
        end
    endtask

    task automatic test_early_release();
        logic [1:0] seq [7];
        seq = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
        we0 = 1'b0; we1 = 1'b0; addr0 = 5'd9; addr1 = 5'd20;
        for (int k = 0; k < 7 + RL + 1; k++) begin
            req0 = (k < 7) && (k != 2);
            req1 = (k < 7);
            eval();
            n_tests++;
            if (obs_gnt !== exp_gnt) begin n_fail++; $display("FAIL early_gnt k=%0d got=%b exp=%b", k, obs_gnt, exp_gnt); end
            if (k < 7) begin
                n_tests++;
                if (obs_gnt !== seq[k]) begin n_fail++; $display("FAIL early_seq k=%0d got=%b exp=%b", k, obs_gnt, seq[k]); end
            end
            n_tests++;
            if (obs_rv !== exp_rv) begin n_fail++; $display("FAIL early_rvalid k=%0d got=%b exp=%b", k, obs_rv, exp_rv); end
            if (exp_rv != 2'b00) begin
                n_tests++;
                if (obs_rd !== exp_rd) begin n_fail++; $display("FAIL early_rdata k=%0d got=%h exp=%h", k, obs_rd, exp_rd); end
            end
        end
    endtask

    task automatic test_coherence();
        for (int k = 0; k < RL + 3; k++) begin
            req0 = (k == 0); we0 = 1'b1; addr0 = 5'd5; wdata0 = 16'hBEEF;
            req1 = (k == 1); we1 = 1'b0; addr1 = 5'd5;
            eval();
            n_tests++;
            if (obs_gnt !== exp_gnt) begin n_fail++; $display("FAIL coh_gnt k=%0d got=%b exp=%b", k, obs_gnt, exp_gnt); end
            n_tests++;
            if (obs_rv !== exp_rv) begin n_fail++; $display("FAIL coh_rvalid k=%0d got=%b exp=%b", k, obs_rv, exp_rv); end
            if (k == 1 + RL) begin
                n_tests++;
                if (obs_rv !== 2'b10 || obs_rd !== 16'hBEEF) begin
                    n_fail++; $display("FAIL coh_return got rvalid=%b rdata=%h exp 10/beef", obs_rv, obs_rd);
                end
            end
        end
    endtask

    task automatic test_reset_mid_read();
        we0 = 1'b0; addr0 = 5'd7; req1 = 1'b0;
        for (int k = 0; k < 5 + RL + 2; k++) begin
            req0 = (k == 0) || (k == 5);
            rst  = (k == 1);
            eval();
            n_tests++;
            if (obs_gnt !== exp_gnt) begin n_fail++; $display("FAIL rstmid_gnt k=%0d got=%b exp=%b", k, obs_gnt, exp_gnt); end
            n_tests++;
            if (obs_rv !== exp_rv || obs_rv !== ((k == 5 + RL) ? 2'b01 : 2'b00)) begin
                n_fail++; $display("FAIL rstmid_rvalid k=%0d got=%b exp=%b", k, obs_rv, exp_rv);
            end
            if (k == 5 + RL) begin
                n_tests++;
                if (obs_rd !== exp_rd) begin n_fail++; $display("FAIL rstmid_rdata got=%h exp=%h", obs_rd, exp_rd); end
            end
        end
    endtask

    task automatic test_random();
        req0 = 1'b0; req1 = 1'b0;
        for (int k = 0; k < 400 + RL + 1; k++) begin
            if (k >= 400) begin
                req0 = 1'b0; req1 = 1'b0;
            end else begin
                if (!req0 || m_g == 0) begin
                    req0 = ($urandom_range(0, 3) != 0); we0 = $urandom_range(0, 1) == 1;
                    addr0 = 5'($urandom); wdata0 = 16'($urandom);
                end
                if (!req1 || m_g == 1) begin
                    req1 = ($urandom_range(0, 3) != 0); we1 = $urandom_range(0, 1) == 1;
                    addr1 = 5'($urandom); wdata1 = 16'($urandom);
                end
            end
            m_g = -1;
            eval();
            n_tests++;
            if (obs_gnt !== exp_gnt) begin n_fail++; $display("FAIL rand_gnt k=%0d got=%b exp=%b", k, obs_gnt, exp_gnt); end
            n_tests++;
            if (obs_wren !== exp_wren || obs_addr !== exp_addr || obs_wd !== exp_wd) begin
                n_fail++; $display("FAIL rand_ram k=%0d got %b/%0d/%h exp %b/%0d/%h", k, obs_wren, obs_addr, obs_wd, exp_wren, exp_addr, exp_wd);
            end
            n_tests++;
            if (obs_rv !== exp_rv) begin n_fail++; $display("FAIL rand_rvalid k=%0d got=%b exp=%b", k, obs_rv, exp_rv); end
            if (exp_rv != 2'b00) begin
                n_tests++;
                if (obs_rd !== exp_rd) begin n_fail++; $display("FAIL rand_rdata k=%0d got=%h exp=%h", k, obs_rd, exp_rd); end
            end
        end
    endtask

    initial begin
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        m_owner = -1; m_last = 1; m_count = 0; cyc = 0; m_g = -1;
        for (int i = 0; i < 16; i++) begin rv_v[i] = 1'b0; rv_id[i] = 1'b0; rv_d[i] = '0; end
        for (int i = 0; i < 32; i++) shadow[i] = '0;
        #2 rst = 1'b1;
        @(posedge clock);
        #1;
        test_reset();
        test_fill();
        test_single_burst();
        test_contention();
        test_early_release();
        test_coherence();
        test_reset_mid_read();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester arbiter for the shared single-port 32x16 RAM. It lets a loader, or a second mover, share the RAM with the data mover without address or write collisions. Arbitration is round-robin with a bounded burst length. Read data is returned to the requester that issued the read, tagged through a latency pipeline. It sits between the requesters and the RAM instance, and its port names line up with the RAM's address/data/wren/q pins.

## Interface
- ADDR_W, 5, RAM address width
- DATA_W, 16, RAM data width
- READ_LATENCY, 1, cycles from accepted read to valid ram_q (>=1)
- MAX_BURST, 4, max consecutive beats one owner keeps while the other requests (>=1)
- clock  in  1  single clock domain, rising edge
- rst  in  1  asynchronous, active-high reset
- req0 / req1  in  1  access request, held until granted
- we0 / we1  in  1  1 = write, 0 = read; qualified by req
- addr0 / addr1  in  ADDR_W  access address
- wdata0 / wdata1  in  DATA_W  write data
- gnt0 / gnt1  out  1  access accepted this cycle (combinational, one-hot or zero)
- rvalid0 / rvalid1  out  1  rdata valid for that requester this cycle
- rdata  out  DATA_W  read data, wired directly from ram_q
- ram_addr  out  ADDR_W  to RAM address
- ram_data  out  DATA_W  to RAM data
- ram_wren  out  1  to RAM wren
- ram_q  in  DATA_W  from RAM q

## Operation
- **Registered state:**
  - owner: NONE/0/1
  - last: id of the last requester served
  - count: 0..MAX_BURST, consecutive beats by owner
  - tag pipeline: READ_LATENCY stages of {valid, id}
- **Grant decision (combinational):**
  - Owner i keeps the grant if req_i and (count < MAX_BURST or !req_j).
  - Otherwise, if exactly one requester is active, grant it.
  - If both are active, grant the id != last.
  - If none are active, no grant.
- **Beat:** a cycle with gnt_i=1; req_i=1 is implied.
- **RAM mux:**
  - ram_addr/ram_data/ram_wren follow the granted requester; ram_wren = we of the grantee.
  - With no grant: ram_wren=0, ram_addr=0, ram_data=0.
- **Update on each edge:**
  - With a grant: owner <= grantee, last <= grantee. count <= min(count+1, MAX_BURST) if grantee == previous owner, else 1.
  - With no grant: owner <= NONE, count <= 0; last is held.
- **Read return:**
  - An accepted read beat pushes {1, id} into stage 0; a write or idle cycle pushes {0, x}.
  - The stage READ_LATENCY-1 output drives rvalid_id.
  - rdata is always ram_q; it is meaningful only when rvalid is high.
- **Boundary behaviour:**
  - Owner drops req: the other requester is granted in the same cycle if requesting. count restarts at 1.
  - Sole requester: keeps the grant indefinitely; count saturates at MAX_BURST.
  - Write then read of the same address in consecutive beats: read returns the new data (RAM old-data/new-data behaviour is not relied on within one cycle).
  - Reset mid-operation: the pipeline is cleared immediately, so in-flight reads never produce rvalid. Requesters must reissue.

## Timing
- **Reset values (while rst=1 and after, until first edge):**
  - owner=NONE, last=1 (req0 wins the first tie), count=0, pipeline all invalid.
  - gnt0=gnt1=0, ram_wren=0, ram_addr=0, ram_data=0, rvalid0=rvalid1=0.
  - gnt is forced 0 while rst=1.
- **Grant latency:** 0 cycles. req asserted in cycle N is granted in cycle N if it wins arbitration.
- **Read latency:** read beat in cycle N gives rvalid_id=1 and rdata valid in cycle N+READ_LATENCY, for exactly one cycle.
- **Throughput:** one beat per cycle sustained. Under constant contention, grants alternate in blocks of MAX_BURST with no idle cycle at switchover.
- **Request hold rule:** a requester holds req/we/addr/wdata stable until it sees gnt high. It may change them the cycle after.

## Test plan
- **Reset:** rst=1 with req0=req1=1 -> gnt0=gnt1=0, ram_wren=0, rvalid=0. Release rst -> first cycle gnt0=1.
- **Single writer burst:** req1=we1=1, addr1 steps 3..10, wdata1=0x1000+addr -> gnt1 high 8 consecutive cycles, ram_wren high 8 cycles, gnt0 never high.
- **Contention, continuous reads, MAX_BURST=4:** grant sequence 0,0,0,0,1,1,1,1,0... Each rvalid_id pulses READ_LATENCY cycles after its beat with the id-correct data.
- **Early release:** owner 0 drops req after 2 beats while req1=1 -> gnt1 in that same cycle. A later contention block gives req1 4 beats before switching.
- **Cross-requester coherence:** req0 writes 0xBEEF to addr 5 in cycle N. req1 reads addr 5 in cycle N+1 -> rvalid1 in cycle N+1+READ_LATENCY with rdata=0xBEEF.
- **Reset mid-read:** read by req0 accepted, then rst pulsed before the return cycle -> rvalid0 never asserts. After release, a fresh read returns normally.
